// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: reset level, stall encodings and track state types shared by the pipeline sequencer
package pipe_ctrl_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  typedef enum logic [1:0] {MC_IDLE, MC_RUN, MC_DONE} mc_state_e;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;
endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// pipe_mc_seq: multi-cycle EX occupancy tracker (down-counter plus IDLE/RUN/DONE state)
module pipe_mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  input  logic abort,
  output logic busy,
  output logic finish
);
  localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  mc_state_e st_q;
  logic [CW-1:0] cnt_q;
  assign busy = st_q != MC_IDLE;
  // the start cycle is the first of MC_LATENCY EX cycles, so RUN loads one less than the remaining count
  assign finish = !abort && !hold && ((st_q == MC_RUN && cnt_q == '0) || st_q == MC_DONE);
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      st_q  <= MC_IDLE;
      cnt_q <= '0;
    end else if (abort) begin
      st_q <= MC_IDLE;
    end else begin
      case (st_q)
        MC_IDLE: if (start) begin
          st_q  <= MC_RUN;
          cnt_q <= CW'(MC_LATENCY - 2);
        end
        MC_RUN: if (cnt_q == '0) st_q <= hold ? MC_DONE : MC_IDLE;
                else cnt_q <= cnt_q - 1'b1;
        MC_DONE: if (!hold) st_q <= MC_IDLE;
        default: st_q <= MC_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with memory-wait tracking and deferred redirect flush
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY   = 32,
  parameter int MEM_WAIT_MAX = 15,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            ex_mc_req,
  input  logic            mem_req,
  input  logic            mem_ack,
  input  logic            flush_req,
  input  logic [PC_W-1:0] flush_pc_in,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [PC_W-1:0] flush_pc,
  output logic            mc_busy,
  output logic            mc_finish,
  output logic            mem_timeout
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  mem_state_e mem_q;
  logic [WW-1:0] wcnt_q;
  logic pend_q, flush_q;
  logic [PC_W-1:0] ppc_q, flush_pc_q;
  logic mem_start, mem_stall, ex_stall, fl_any, fl_go;
  logic [PC_W-1:0] pc_sel;
  // a flushed MEM stage cannot open a new access in the flush cycle
  assign mem_start   = mem_req && !mem_ack && !flush_q;
  assign mem_stall   = (mem_q == MEM_WAIT) ? (!mem_ack && wcnt_q != WW'(MEM_WAIT_MAX)) : mem_start;
  assign mem_timeout = mem_q == MEM_WAIT && !mem_ack && wcnt_q == WW'(MEM_WAIT_MAX);
  assign ex_stall    = mc_busy ? !mc_finish : ex_mc_req;
  assign stall = (rst == RstEnable || flush_q) ? StallNone :
                 mem_stall ? StallMem : ex_stall ? StallEx : stallreq_id ? StallId : StallNone;
  assign fl_any   = pend_q || flush_req;
  assign fl_go    = fl_any && !mem_stall;
  assign pc_sel   = flush_req ? flush_pc_in : ppc_q;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
  pipe_mc_seq #(.MC_LATENCY(MC_LATENCY)) u_mc (
    .clk   (clk),
    .rst   (rst),
    .start (ex_mc_req),
    .hold  (mem_stall),
    .abort (flush_q),
    .busy  (mc_busy),
    .finish(mc_finish)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      mem_q      <= MEM_IDLE;
      wcnt_q     <= '0;
      pend_q     <= 1'b0;
      ppc_q      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      mem_q      <= mem_stall ? MEM_WAIT : MEM_IDLE;
      wcnt_q     <= (mem_q == MEM_IDLE) ? WW'(1) : wcnt_q + 1'b1;
      pend_q     <= fl_any && mem_stall;
      ppc_q      <= pc_sel;
      flush_q    <= fl_go;
      flush_pc_q <= fl_go ? pc_sel : '0;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus scored per cycle against an occupancy/wait-count reference model
module tb_pipe_ctrl;
  localparam int LAT = 32;
  localparam int MWM = 15;
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        fin;
    logic        to;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stallreq_id = 1'b0, ex_mc_req = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, flush_req = 1'b0;
  logic [31:0] flush_pc_in = '0;
  logic [5:0] stall;
  logic flush, mc_busy, mc_finish, mem_timeout;
  logic [31:0] flush_pc;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;
  bit mc_on = 0, fl_now = 0, pend = 0, last_fin = 0;
  int mc_el = 0, mem_k = -1;
  logic [31:0] fl_pc = '0, pend_pc = '0;
  bit r_ex, r_mr, r_ma, r_sid, r_fr;
  int ack_odds;
  pipe_ctrl #(.MC_LATENCY(LAT), .MEM_WAIT_MAX(MWM), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
    .mem_req(mem_req), .mem_ack(mem_ack), .flush_req(flush_req), .flush_pc_in(flush_pc_in),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .mc_busy(mc_busy),
    .mc_finish(mc_finish), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endfunction
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_pop++;
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("mc_busy", 32'(mc_busy), 32'(e.busy));
      chk("mc_finish", 32'(mc_finish), 32'(e.fin));
      chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
      if (e.flush) chk("flush_pc", flush_pc, e.pc);
    end
  end
  task automatic cycle(input bit ex, input bit mr, input bit ma, input bit sid, input bit fr,
                       input logic [31:0] fpc);
    exp_t e;
    bit m_st, m_to, fin, ex_st, fl_any;
    int k;
    logic [31:0] pc;
    ex_mc_req = ex; mem_req = mr; mem_ack = ma; stallreq_id = sid; flush_req = fr; flush_pc_in = fpc;
    k    = (mem_k < 0) ? 0 : mem_k;
    m_st = !fl_now && mr && !ma && k < MWM;
    m_to = !fl_now && mr && !ma && k == MWM;
    fin  = mc_on && (mc_el + 1 >= LAT) && !m_st && !fl_now;
    ex_st = !fl_now && (mc_on ? !fin : ex);
    e.stall = fl_now ? 6'h00 : m_st ? 6'h1f : ex_st ? 6'h0f : sid ? 6'h07 : 6'h00;
    e.flush = fl_now; e.pc = fl_pc; e.busy = mc_on; e.fin = fin; e.to = m_to;
    sb.push_back(e);
    n_push++;
    last_fin = fin;
    mem_k = m_st ? k + 1 : -1;
    if (fl_now || fin) mc_on = 0;
    else if (mc_on) mc_el++;
    else if (ex) begin mc_on = 1; mc_el = 1; end
    fl_any = pend || fr;
    pc = fr ? fpc : pend_pc;
    fl_now = fl_any && !m_st;
    pend = fl_any && m_st;
    pend_pc = pc;
    fl_pc = pc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset(input int hold_cycles);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(mc_busy), 0);
    chk("rst_finish", 32'(mc_finish), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    chk("rst_flush_pc", flush_pc, 0);
    repeat (hold_cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_stall", 32'(stall), 0);
    chk("rst_hold_busy", 32'(mc_busy), 0);
    ex_mc_req = 0; mem_req = 0; mem_ack = 0; stallreq_id = 0; flush_req = 0; flush_pc_in = '0;
    rst = 1'b1;
    mc_on = 0; mc_el = 0; mem_k = -1; fl_now = 0; pend = 0; fl_pc = '0; pend_pc = '0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset(2);
    idle(4);
    for (int i = 0; i < LAT; i++) cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < LAT; i++) cycle(1, 0, 0, 1, 0, 0);
    idle(1);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i <= MWM; i++) cycle(0, 1, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < LAT + 3; i++) cycle(1, i >= LAT - 4, i == LAT + 2, 0, 0, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 32'hBFC00380);
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 22; i++) cycle(1, 0, 0, 0, 0, 0);
    do_reset(2);
    idle(3);
    for (int c = 0; c < 3000; c++) begin
      ack_odds = ((c / 500) % 2 == 1) ? 1 : 7;
      r_ex  = fl_now ? 1'($urandom_range(0, 1)) : mc_on ? 1'b1 : ($urandom_range(0, 15) == 0);
      r_mr  = fl_now ? 1'b0 : (mem_k >= 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      r_ma  = r_mr && ($urandom_range(0, ack_odds) == 0);
      r_sid = ($urandom_range(0, 3) == 0);
      r_fr  = ($urandom_range(0, 24) == 0);
      cycle(r_ex, r_mr, r_ma, r_sid, r_fr, $urandom);
    end
    for (int i = 0; i < 200 && (mc_on || mem_k >= 0 || pend || fl_now); i++)
      cycle(mc_on, mem_k >= 0, mem_k >= 0, 0, 0, 0);
    idle(2);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    chk("sb_pops", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS32 core.
- Generates per-stage stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Tracks two kinds of long-running events:
  - multi-cycle EX operations (mult/div), using an internal cycle counter;
  - data-memory bus waits, using a req/ack handshake with timeout.
- Applies exception/redirect flushes with a registered target PC.

Parameters:
- MC_LATENCY, 32, number of cycles a multi-cycle EX op occupies EX (≥2).
- MEM_WAIT_MAX, 15, maximum wait cycles on a data-memory access before timeout (≥1).
- PC_W, 32, width of the redirect PC.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard from ID.
- ex_mc_req  in  1  EX holds a multi-cycle op; level, held until mc_finish.
- mem_req  in  1  MEM stage has an outstanding data access.
- mem_ack  in  1  bus completes the access this cycle.
- flush_req  in  1  exception/redirect request; 1-cycle pulse.
- flush_pc_in  in  PC_W  redirect target, valid with flush_req.
- stall  out  6  [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]reserved (always 0).
- flush  out  1  clear all pipeline registers; 1-cycle pulse.
- flush_pc  out  PC_W  PC to load when flush=1.
- mc_busy  out  1  multi-cycle op in progress.
- mc_finish  out  1  EX result valid; EX advances this cycle.
- mem_timeout  out  1  1-cycle pulse; access abandoned after MEM_WAIT_MAX wait cycles.

Behaviour:
- Reset (rst=0, async): MC=MC_IDLE, MEM=MEM_IDLE, counters 0, pending flush 0. All outputs 0, flush_pc=0.
- Stall encodings are combinational from the current state and inputs; the highest applicable encoding wins:
  - MEM wait: 6'b011111
  - EX multi-cycle: 6'b001111
  - ID hazard: 6'b000111
  - none: 6'b000000
- MC track states: MC_IDLE, MC_RUN, MC_DONE.
  - MC_IDLE & ex_mc_req & !flush → MC_RUN; count=MC_LATENCY-1. Stall ≥001111 from this same cycle.
  - MC_RUN: count decrements each cycle.
    - At count==0 with no MEM stall: mc_finish=1, EX stall released that cycle, → MC_IDLE.
    - At count==0 with MEM stall active: → MC_DONE.
  - MC_DONE: holds; mc_finish=1 on the first cycle the MEM stall is absent, then → MC_IDLE.
  - ex_mc_req is ignored in the cycle mc_finish=1, because the same instruction is still in EX.
  - mc_busy = (MC != MC_IDLE).
- MEM track states: MEM_IDLE, MEM_WAIT.
  - mem_req & mem_ack in the same cycle: no stall, stay in MEM_IDLE.
  - mem_req & !mem_ack: stall=011111 that cycle; → MEM_WAIT; wcnt=1.
  - MEM_WAIT & mem_ack: stall released that cycle; → MEM_IDLE.
  - MEM_WAIT & !mem_ack & wcnt==MEM_WAIT_MAX: mem_timeout=1, stall released, → MEM_IDLE.
  - Otherwise wcnt increments.
- Flush:
  - flush_req sampled at edge N → flush=1 and flush_pc=flush_pc_in during cycle N+1.
  - In the flush cycle, stall=0 and the MC track is forced to MC_IDLE at the next edge; no mc_finish.
  - flush_req while MEM is stalled: the request and PC are latched as pending and the access is not aborted. flush is issued the cycle after the MEM track returns to MEM_IDLE.
  - A new flush_req while one is pending overwrites the pending PC.
- Simultaneous events:
  - stallreq_id with an MC/MEM stall: the higher encoding covers it.
  - mem_ack and MC count==0 in the same cycle: mc_finish=1, stall=0.

Decomposition:
- Shared defines file holds:
  - `RstEnable (1'b0 for this block);
  - stall encodings `StallNone, `StallId, `StallEx, `StallMem;
  - MC and MEM state encodings.
- One sub-module, pipe_mc_seq, implements the MC track (counter plus 3-state FSM) with inputs start, hold, abort and outputs busy, finish.
- pipe_ctrl keeps the MEM track, flush register and stall merge.

Test Plan:
- Reset mid-MC_RUN: drop rst at count=10 → stall=0, mc_busy=0 immediately; after release, idle with no mc_finish.
- ex_mc_req at cycle 5, MC_LATENCY=32:
  - stall=001111 on cycles 5..35;
  - mc_finish=1 only in cycle 36 with stall=0;
  - mc_busy low from cycle 37.
- mem_req without ack for 3 cycles, then ack → stall=011111 for 3 cycles, 0 in the ack cycle. With no ack at all: mem_timeout pulse on the 15th wait cycle, no further stall.
- MC count reaches 0 during a MEM wait: no mc_finish until the ack cycle; mc_finish=1 exactly in the ack cycle, stall=0.
- flush_req with PC 0xBFC00380 while MEM is waiting: no flush until ack. The cycle after ack: flush=1, flush_pc=0xBFC00380, stall=0.
- stallreq_id alone → stall=000111. stallreq_id together with ex_mc_req → 001111.
